// File: rtl/sao_offset_sched.sv
// SAO decision sequencer: streams the 32-entry statistics buffer through the offset
// calculator and keeps the cheapest of EO class, 4-band BO window, or SAO off.
module sao_offset_sched #(
  parameter int SAO_DIF_WIDTH = 18,
  parameter int SAO_NUM_WIDTH = 12,
  parameter int SAO_DIS_WIDTH = 20
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start_i,
  output logic                              busy_o,
  output logic                              done_o,
  output logic                              rd_en_o,
  output logic [4:0]                        rd_addr_o,
  input  logic signed [SAO_DIF_WIDTH-1:0]   rd_stat_i,
  input  logic [SAO_NUM_WIDTH-1:0]          rd_num_i,
  output logic signed [SAO_DIF_WIDTH-1:0]   cal_stat_o,
  output logic [SAO_NUM_WIDTH-1:0]          cal_num_o,
  output logic [4:0]                        cal_mode_o,
  output logic                              cal_valid_o,
  input  logic signed [2:0]                 cal_offset_i,
  input  logic signed [SAO_DIS_WIDTH-1:0]   cal_dist_i,
  output logic [2:0]                        best_type_o,
  output logic [3:0]                        best_band_o,
  output logic [11:0]                       best_offset_o,
  output logic signed [SAO_DIS_WIDTH+1:0]   best_cost_o
);

  localparam int CW = SAO_DIS_WIDTH + 2;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

  state_t state, state_next;

  logic [4:0]           addr_cnt;
  logic                 drain_cnt;
  logic                 rd_vld_q;
  logic [4:0]           rd_idx_q;
  logic                 start_acc;

  logic signed [CW-1:0] class_sum;
  logic signed [CW-1:0] dist_hist [3];
  logic [2:0]           off_hist  [3];
  logic signed [CW-1:0] dist_ext;
  logic signed [CW-1:0] eo_sum;
  logic signed [CW-1:0] win_sum;
  logic signed [CW-1:0] cand_cost;
  logic [11:0]          cand_off;
  logic [2:0]           cand_type;
  logic [3:0]           cand_band;
  logic                 cand_valid;
  logic                 take;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start_i) state_next = S_READ;
      S_READ:  if (addr_cnt == 5'd31) state_next = S_DRAIN;
      S_DRAIN: if (drain_cnt) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy_o    = (state != S_IDLE);
    done_o    = (state == S_DONE);
    rd_en_o   = (state == S_READ);
    rd_addr_o = addr_cnt;
  end

  assign start_acc = (state == S_IDLE) && start_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_cnt  <= '0;
      drain_cnt <= 1'b0;
    end else begin
      addr_cnt  <= (state == S_READ) ? addr_cnt + 5'd1 : 5'd0;
      drain_cnt <= (state == S_DRAIN) ? !drain_cnt : 1'b0;
    end
  end

  // Buffer data lands one cycle after the address; register it toward the calculator.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_vld_q    <= 1'b0;
      rd_idx_q    <= '0;
      cal_valid_o <= 1'b0;
      cal_mode_o  <= '0;
      cal_stat_o  <= '0;
      cal_num_o   <= '0;
    end else begin
      rd_vld_q    <= rd_en_o;
      rd_idx_q    <= rd_addr_o;
      cal_valid_o <= rd_vld_q;
      cal_mode_o  <= rd_vld_q ? rd_idx_q  : 5'd0;
      cal_stat_o  <= rd_vld_q ? rd_stat_i : '0;
      cal_num_o   <= rd_vld_q ? rd_num_i  : '0;
    end
  end

  assign dist_ext = {{2{cal_dist_i[SAO_DIS_WIDTH-1]}}, cal_dist_i};
  assign eo_sum   = class_sum + dist_ext;
  assign win_sum  = dist_ext + dist_hist[0] + dist_hist[1] + dist_hist[2];
  assign cand_off = {cal_offset_i, off_hist[0], off_hist[1], off_hist[2]};

  // Mode 19 has low bits 3, so subtracting 3 from the low nibble yields the start band.
  always_comb begin
    cand_valid = 1'b0;
    cand_cost  = eo_sum;
    cand_type  = 3'd5;
    cand_band  = 4'd0;
    if (cal_valid_o && !cal_mode_o[4] && (cal_mode_o[1:0] == 2'd3)) begin
      cand_valid = 1'b1;
      cand_cost  = eo_sum;
      cand_type  = {1'b0, cal_mode_o[3:2]};
    end else if (cal_valid_o && (cal_mode_o >= 5'd19)) begin
      cand_valid = 1'b1;
      cand_cost  = win_sum;
      cand_type  = 3'd4;
      cand_band  = cal_mode_o[3:0] - 4'd3;
    end
  end

  assign take = cand_valid && (cand_cost < best_cost_o);

  always_ff @(posedge clk) begin
    if (rst) begin
      class_sum     <= '0;
      dist_hist     <= '{default: '0};
      off_hist      <= '{default: '0};
      best_type_o   <= '0;
      best_band_o   <= '0;
      best_offset_o <= '0;
      best_cost_o   <= '0;
    end else if (start_acc) begin
      class_sum     <= '0;
      dist_hist     <= '{default: '0};
      off_hist      <= '{default: '0};
      best_type_o   <= 3'd5;
      best_band_o   <= '0;
      best_offset_o <= '0;
      best_cost_o   <= '0;
    end else if (cal_valid_o) begin
      class_sum    <= (cal_mode_o[4] || (cal_mode_o[1:0] == 2'd3)) ? '0 : eo_sum;
      dist_hist[0] <= dist_ext;
      dist_hist[1] <= dist_hist[0];
      dist_hist[2] <= dist_hist[1];
      off_hist[0]  <= cal_offset_i;
      off_hist[1]  <= off_hist[0];
      off_hist[2]  <= off_hist[1];
      if (take) begin
        best_type_o   <= cand_type;
        best_band_o   <= cand_band;
        best_offset_o <= cand_off;
        best_cost_o   <= cand_cost;
      end
    end
  end

endmodule

// File: tb/tb_sao_offset_sched.sv
// Bench for sao_offset_sched: models the statistics buffer and the offset calculator,
// and scoreboards both the calculator feed and the final decision.
module tb_sao_offset_sched;

  logic               clk;
  logic               rst;
  logic               start_i;
  logic               busy_o;
  logic               done_o;
  logic               rd_en_o;
  logic [4:0]         rd_addr_o;
  logic signed [17:0] rd_stat_i;
  logic [11:0]        rd_num_i;
  logic signed [17:0] cal_stat_o;
  logic [11:0]        cal_num_o;
  logic [4:0]         cal_mode_o;
  logic               cal_valid_o;
  logic signed [2:0]  cal_offset_i;
  logic signed [19:0] cal_dist_i;
  logic [2:0]         best_type_o;
  logic [3:0]         best_band_o;
  logic [11:0]        best_offset_o;
  logic signed [21:0] best_cost_o;

  typedef struct {
    logic [4:0]         mode;
    logic signed [17:0] stat;
    logic [11:0]        num;
  } cal_exp_t;

  typedef struct {
    logic [2:0]         typ;
    logic [3:0]         band;
    logic [11:0]        off;
    logic signed [21:0] cost;
    int                 done_cyc;
  } res_exp_t;

  cal_exp_t           cal_q[$];
  res_exp_t           res_q[$];
  cal_exp_t           mon_ce;
  res_exp_t           mon_re;
  logic signed [17:0] mem_stat [32];
  logic [11:0]        mem_num  [32];
  int                 total = 0;
  int                 bad = 0;
  int                 cyc = 0;
  int                 cq;
  int                 cd;

  sao_offset_sched dut (
    .clk(clk), .rst(rst), .start_i(start_i), .busy_o(busy_o), .done_o(done_o),
    .rd_en_o(rd_en_o), .rd_addr_o(rd_addr_o), .rd_stat_i(rd_stat_i), .rd_num_i(rd_num_i),
    .cal_stat_o(cal_stat_o), .cal_num_o(cal_num_o), .cal_mode_o(cal_mode_o),
    .cal_valid_o(cal_valid_o), .cal_offset_i(cal_offset_i), .cal_dist_i(cal_dist_i),
    .best_type_o(best_type_o), .best_band_o(best_band_o), .best_offset_o(best_offset_o),
    .best_cost_o(best_cost_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (rd_en_o) begin
      rd_stat_i <= mem_stat[rd_addr_o];
      rd_num_i  <= mem_num[rd_addr_o];
    end
  end

  // Calculator model: truncated stat/num clipped to 3-bit signed; EO cat 0/1 non-negative, 2/3 non-positive.
  function automatic int calc_q(input int s, input int n, input int mode);
    int q;
    if (n == 0) q = 0;
    else q = s / n;
    if (q > 3) q = 3;
    if (q < -4) q = -4;
    if (mode < 16) begin
      if ((mode % 4) < 2) begin
        if (q < 0) q = 0;
      end else if (q > 0) q = 0;
    end
    return q;
  endfunction

  function automatic int calc_dist(input int s, input int n, input int q);
    return n * q * q - 2 * q * s;
  endfunction

  always_comb begin
    cq = 0;
    cd = 0;
    cq = calc_q(int'(cal_stat_o), int'(cal_num_o), int'(cal_mode_o));
    cd = calc_dist(int'(cal_stat_o), int'(cal_num_o), cq);
    cal_offset_i = 3'(cq);
    cal_dist_i   = 20'(cd);
  end

  function automatic res_exp_t ref_decide();
    res_exp_t r;
    int q[32];
    int d[32];
    int best;
    int sum;
    for (int k = 0; k < 32; k++) begin
      q[k] = calc_q(int'(mem_stat[k]), int'(mem_num[k]), k);
      d[k] = calc_dist(int'(mem_stat[k]), int'(mem_num[k]), q[k]);
    end
    best = 0;
    r.typ = 3'd5; r.band = 4'd0; r.off = 12'd0; r.done_cyc = 0;
    for (int c = 0; c < 4; c++) begin
      sum = d[4*c] + d[4*c+1] + d[4*c+2] + d[4*c+3];
      if (sum < best) begin
        best = sum; r.typ = 3'(c); r.band = 4'd0;
        for (int i = 0; i < 4; i++) r.off[3*i +: 3] = 3'(q[4*c+i]);
      end
    end
    for (int b = 0; b < 13; b++) begin
      sum = d[16+b] + d[17+b] + d[18+b] + d[19+b];
      if (sum < best) begin
        best = sum; r.typ = 3'd4; r.band = 4'(b);
        for (int i = 0; i < 4; i++) r.off[3*i +: 3] = 3'(q[16+b+i]);
      end
    end
    r.cost = 22'(best);
    return r;
  endfunction

  always @(negedge clk) begin
    total++;
    if (cal_valid_o) begin
      if (cal_q.size() == 0) begin
        bad++;
        $display("[TB] FAIL cal_unexpected: got mode=%0d want no valid", cal_mode_o);
      end else begin
        mon_ce = cal_q.pop_front();
        if (cal_mode_o !== mon_ce.mode || cal_stat_o !== mon_ce.stat || cal_num_o !== mon_ce.num) begin
          bad++;
          $display("[TB] FAIL cal_feed: got mode=%0d stat=%0d num=%0d want mode=%0d stat=%0d num=%0d",
                   cal_mode_o, cal_stat_o, cal_num_o, mon_ce.mode, mon_ce.stat, mon_ce.num);
        end
      end
    end else if (cal_stat_o !== 18'sd0 || cal_num_o !== 12'd0) begin
      bad++;
      $display("[TB] FAIL cal_idle_zero: got stat=%0d num=%0d want 0 0", cal_stat_o, cal_num_o);
    end
    if (done_o) begin
      total++;
      if (res_q.size() == 0) begin
        bad++;
        $display("[TB] FAIL done_unexpected: got done_o=1 at cycle %0d want none", cyc);
      end else begin
        mon_re = res_q.pop_front();
        if (best_type_o !== mon_re.typ || best_band_o !== mon_re.band ||
            best_offset_o !== mon_re.off || best_cost_o !== mon_re.cost || cyc != mon_re.done_cyc) begin
          bad++;
          $display("[TB] FAIL decision: got type=%0d band=%0d off=%h cost=%0d cyc=%0d want type=%0d band=%0d off=%h cost=%0d cyc=%0d",
                   best_type_o, best_band_o, best_offset_o, best_cost_o, cyc,
                   mon_re.typ, mon_re.band, mon_re.off, mon_re.cost, mon_re.done_cyc);
        end
      end
    end
  end

  task automatic clear_mem();
    for (int k = 0; k < 32; k++) begin
      mem_stat[k] = '0;
      mem_num[k]  = '0;
    end
  endtask

  // Queues expected traffic, pulses (or holds) start and waits up to 60 cycles for done_o.
  task automatic run_decision(input res_exp_t exp, input bit hold_start, output bit seen);
    cal_exp_t ce;
    int n;
    for (int k = 0; k < 32; k++) begin
      ce.mode = 5'(k); ce.stat = mem_stat[k]; ce.num = mem_num[k];
      cal_q.push_back(ce);
    end
    exp.done_cyc = cyc + 35;
    res_q.push_back(exp);
    start_i = 1'b1;
    @(negedge clk);
    if (!hold_start) start_i = 1'b0;
    n = 0;
    while (!done_o && n < 60) begin
      @(negedge clk);
      n++;
    end
    seen = done_o;
    start_i = 1'b0;
    @(negedge clk);
    if (!seen) begin
      cal_q.delete();
      res_q.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start_i = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (busy_o !== 1'b0 || done_o !== 1'b0 || rd_en_o !== 1'b0 || rd_addr_o !== 5'd0 ||
        cal_valid_o !== 1'b0 || cal_mode_o !== 5'd0 || best_type_o !== 3'd0 ||
        best_band_o !== 4'd0 || best_offset_o !== 12'd0 || best_cost_o !== 22'sd0) begin
      bad++;
      $display("[TB] FAIL reset_state: got busy=%b done=%b rd_en=%b addr=%0d valid=%b type=%0d cost=%0d want all 0",
               busy_o, done_o, rd_en_o, rd_addr_o, cal_valid_o, best_type_o, best_cost_o);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_case(input string name, input logic [2:0] typ, input logic [3:0] band,
                           input logic [11:0] off, input int cost);
    res_exp_t e;
    bit seen;
    e.typ = typ; e.band = band; e.off = off; e.cost = 22'(cost); e.done_cyc = 0;
    run_decision(e, 1'b0, seen);
    total++;
    if (!seen) begin
      bad++;
      $display("[TB] FAIL %s_timeout: got no done_o want done_o within 60 cycles", name);
    end
    total++;
    if (busy_o !== 1'b0 || cal_q.size() != 0 || res_q.size() != 0) begin
      bad++;
      $display("[TB] FAIL %s_drain: got busy=%b cal_q=%0d res_q=%0d want 0 0 0",
               name, busy_o, cal_q.size(), res_q.size());
    end
  endtask

  task automatic test_all_zero();
    clear_mem();
    test_case("all_zero", 3'd5, 4'd0, 12'h000, 0);
  endtask

  task automatic test_eo_single();
    clear_mem();
    mem_stat[8] = 18'sd20; mem_num[8] = 12'd10;
    test_case("eo_single", 3'd2, 4'd0, 12'h002, -40);
  endtask

  task automatic test_eo_clip();
    clear_mem();
    mem_stat[0] = -18'sd20; mem_num[0] = 12'd10;
    test_case("eo_clip", 3'd5, 4'd0, 12'h000, 0);
  endtask

  task automatic test_bo_window();
    clear_mem();
    for (int k = 17; k <= 20; k++) begin mem_stat[k] = 18'sd30; mem_num[k] = 12'd10; end
    test_case("bo_band1", 3'd4, 4'd1, 12'h6DB, -360);
    clear_mem();
    for (int k = 20; k <= 23; k++) begin mem_stat[k] = 18'sd30; mem_num[k] = 12'd10; end
    test_case("bo_band4", 3'd4, 4'd4, 12'h6DB, -360);
    clear_mem();
    for (int k = 28; k <= 31; k++) begin mem_stat[k] = 18'sd20; mem_num[k] = 12'd10; end
    test_case("bo_band12", 3'd4, 4'd12, 12'h492, -160);
  endtask

  task automatic test_eo_tie();
    clear_mem();
    mem_stat[1] = 18'sd20; mem_num[1] = 12'd10;
    mem_stat[5] = 18'sd20; mem_num[5] = 12'd10;
    test_case("eo_tie", 3'd0, 4'd0, 12'h010, -40);
  endtask

  task automatic test_abort();
    cal_exp_t ce;
    res_exp_t e;
    bit seen;
    int n;
    clear_mem();
    mem_stat[8] = 18'sd20; mem_num[8] = 12'd10;
    for (int k = 0; k < 8; k++) begin
      ce.mode = 5'(k); ce.stat = mem_stat[k]; ce.num = mem_num[k];
      cal_q.push_back(ce);
    end
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++;
    if (busy_o !== 1'b0 || done_o !== 1'b0 || rd_en_o !== 1'b0 || cal_valid_o !== 1'b0 ||
        best_type_o !== 3'd0 || best_offset_o !== 12'd0 || best_cost_o !== 22'sd0 || cal_q.size() != 0) begin
      bad++;
      $display("[TB] FAIL abort_state: got busy=%b done=%b rd_en=%b valid=%b type=%0d cal_q=%0d want all 0",
               busy_o, done_o, rd_en_o, cal_valid_o, best_type_o, cal_q.size());
    end
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done_o || busy_o) n++;
    end
    total++;
    if (n != 0) begin
      bad++;
      $display("[TB] FAIL abort_quiet: got %0d active cycles want 0", n);
    end
    e.typ = 3'd2; e.band = 4'd0; e.off = 12'h002; e.cost = -22'sd40; e.done_cyc = 0;
    run_decision(e, 1'b1, seen);
    total++;
    if (!seen) begin
      bad++;
      $display("[TB] FAIL abort_restart_timeout: got no done_o want done_o within 60 cycles");
    end
    repeat (3) @(negedge clk);
    total++;
    if (busy_o !== 1'b0 || res_q.size() != 0 || cal_q.size() != 0) begin
      bad++;
      $display("[TB] FAIL abort_restart_idle: got busy=%b res_q=%0d want 0 0", busy_o, res_q.size());
    end
  endtask

  task automatic test_random();
    res_exp_t e;
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 32; k++) begin
        mem_stat[k] = 18'(int'($urandom_range(600)) - 300);
        mem_num[k]  = ($urandom_range(7) == 0) ? 12'd0 : 12'($urandom_range(100, 1));
      end
      e = ref_decide();
      test_case("random", e.typ, e.band, e.off, int'(e.cost));
    end
  endtask

  initial begin
    rst = 1'b1;
    start_i = 1'b0;
    clear_mem();
    test_reset();
    test_all_zero();
    test_eo_single();
    test_eo_clip();
    test_bo_window();
    test_eo_tie();
    test_abort();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no completion want finish before 20000 cycles");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
